// File: rtl/axis_apu_accum.sv
// Lane-wise AXI4-Stream accumulator: sums GROUP beats per lane, TLAST flushes a partial group,
// and results are queued in a small output FIFO so downstream stalls do not block input at once.
module axis_apu_accum #(
   parameter int LANES     = 8,
   parameter int LANE_W    = 16,
   parameter int GROUP     = 2,
   parameter int OUT_DEPTH = 4,
   parameter int TID_W     = 11
) (
   input  logic                        clk,
   input  logic                        ARESETn,
   input  logic                        TVALID_rd,
   output logic                        TREADY_rd,
   input  logic [LANES*LANE_W-1:0]     TDATA_rd,
   input  logic [LANES*LANE_W/8-1:0]   TSTRB_rd,
   input  logic [LANES*LANE_W/8-1:0]   TKEEP_rd,
   input  logic                        TLAST_rd,
   input  logic [TID_W-1:0]            TID_rd,
   output logic                        TVALID_wr,
   input  logic                        TREADY_wr,
   output logic [LANES*LANE_W-1:0]     TDATA_wr,
   output logic [LANES*LANE_W/8-1:0]   TSTRB_wr,
   output logic [LANES*LANE_W/8-1:0]   TKEEP_wr,
   output logic                        TLAST_wr,
   output logic [TID_W-1:0]            TID_wr,
   output logic                        tid_err
);

   localparam int DATA_W = LANES * LANE_W;
   localparam int STRB_W = DATA_W / 8;
   localparam int CNT_W  = (GROUP > 1) ? $clog2(GROUP + 1) : 1;
   localparam int PTR_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int FCNT_W = $clog2(OUT_DEPTH + 1);
   localparam int ENT_W  = DATA_W + TID_W + 1;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_ACCUM     = 2'd1,
      S_ACCUM_NEW = 2'd2
   } state_t;

   function automatic logic [DATA_W-1:0] mask_bytes(input logic [DATA_W-1:0] d,
                                                    input logic [STRB_W-1:0] en);
      logic [DATA_W-1:0] r;
      r = '0;
      for (int b = 0; b < STRB_W; b++) begin
         r[b*8 +: 8] = en[b] ? d[b*8 +: 8] : 8'h00;
      end
      return r;
   endfunction

   // Each lane wraps on its own; carries never cross a lane boundary.
   function automatic logic [DATA_W-1:0] lane_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
      logic [DATA_W-1:0] r;
      r = '0;
      for (int i = 0; i < LANES; i++) begin
         r[i*LANE_W +: LANE_W] = a[i*LANE_W +: LANE_W] + b[i*LANE_W +: LANE_W];
      end
      return r;
   endfunction

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   acc_q, acc_d;
   logic [TID_W-1:0]    pkt_tid_q, pkt_tid_d;
   logic                tid_err_q, tid_err_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
   logic                en_q, en_d;
   logic [ENT_W-1:0]    mem [OUT_DEPTH];

   logic                accept;
   logic                pop;
   logic                push;
   logic [DATA_W-1:0]   masked;
   logic [DATA_W-1:0]   sum;
   logic [DATA_W-1:0]   push_data;
   logic [TID_W-1:0]    push_tid;
   logic                push_last;
   logic [ENT_W-1:0]    head;

   // Ready depends only on registered state; en_q keeps it low while in reset.
   assign TREADY_rd = en_q & (fcnt_q < FCNT_W'(OUT_DEPTH));
   assign accept    = TVALID_rd & TREADY_rd;
   assign TVALID_wr = (fcnt_q != '0);
   assign pop       = TVALID_wr & TREADY_wr;
   assign masked    = mask_bytes(TDATA_rd, TSTRB_rd & TKEEP_rd);
   assign sum       = lane_add(acc_q, masked);
   assign head      = mem[rd_ptr_q];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      pkt_tid_d = pkt_tid_q;
      tid_err_d = tid_err_q;
      push      = 1'b0;
      push_data = masked;
      push_tid  = TID_rd;
      push_last = TLAST_rd;
      if (accept) begin
         case (state_q)
            S_IDLE: begin
               acc_d     = masked;
               pkt_tid_d = TID_rd;
               cnt_d     = CNT_W'(1);
               if (GROUP == 1 || TLAST_rd) begin
                  push  = 1'b1;
                  cnt_d = '0;
               end else begin
                  state_d = S_ACCUM;
               end
            end
            S_ACCUM: begin
               if (TID_rd != pkt_tid_q) tid_err_d = 1'b1;
               if (cnt_q == CNT_W'(GROUP - 1) || TLAST_rd) begin
                  push      = 1'b1;
                  push_data = sum;
                  push_tid  = pkt_tid_q;
                  cnt_d     = '0;
                  state_d   = TLAST_rd ? S_IDLE : S_ACCUM_NEW;
               end else begin
                  acc_d = sum;
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_ACCUM_NEW: begin
               if (TID_rd != pkt_tid_q) tid_err_d = 1'b1;
               acc_d    = masked;
               cnt_d    = CNT_W'(1);
               push_tid = pkt_tid_q;
               if (GROUP == 1 || TLAST_rd) begin
                  push    = 1'b1;
                  cnt_d   = '0;
                  state_d = TLAST_rd ? S_IDLE : S_ACCUM_NEW;
               end else begin
                  state_d = S_ACCUM;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      fcnt_d   = fcnt_q;
      en_d     = 1'b1;
      if (push && !pop)      fcnt_d = fcnt_q + FCNT_W'(1);
      else if (!push && pop) fcnt_d = fcnt_q - FCNT_W'(1);
   end

   always_ff @(posedge clk or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         pkt_tid_q <= '0;
         tid_err_q <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         fcnt_q    <= '0;
         en_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         pkt_tid_q <= pkt_tid_d;
         tid_err_q <= tid_err_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         fcnt_q    <= fcnt_d;
         en_q      <= en_d;
      end
   end

   // Storage is not reset; a push only happens when a slot is free.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= {push_data, push_tid, push_last};
   end

   assign TDATA_wr = TVALID_wr ? head[ENT_W-1 -: DATA_W] : '0;
   assign TID_wr   = TVALID_wr ? head[TID_W:1] : '0;
   assign TLAST_wr = TVALID_wr & head[0];
   assign TSTRB_wr = {STRB_W{TVALID_wr}};
   assign TKEEP_wr = {STRB_W{TVALID_wr}};
   assign tid_err  = tid_err_q;

endmodule
